// File: rtl/lv_mode_fsm.sv
// lv_mode_fsm: low-voltage mode controller.
// Sequences power-up (efuse load, ADC handshake with the one-wire controller),
// runs the operating modes (NORMAL/CFG/BIST/TEST), and latches error sources
// into FAILSAFE or FAULT. Outputs are registered from the next state so that
// o_ctrl_vec and o_int_n change in the same cycle as o_cur_st.
// Build option: define LV_MODE_FSM_BIST_EN to implement the BIST mode; without
// it, BIST is unreachable, bist_en is ignored and o_ctrl_vec[4] stays 0.
module lv_mode_fsm #(
  parameter int ERR_NUM      = 13,
  parameter int REQ_ADC_NUM  = 4,
  parameter int RST_HOLD_CYC = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_power_on,
  input  logic               i_test_mode,
  input  logic               i_efuse_vld,
  output logic               o_fsm_efuse_load_en,
  input  logic               i_efuse_fsm_load_done,
  output logic               o_fsm_ow_ctrl_req_adc,
  input  logic               i_ow_ctrl_fsm_ack_adc,
  input  logic               i_ow_ctrl_fsm_ack_adc_status,
  input  logic [ERR_NUM-1:0] i_err_vec,
  input  logic [ERR_NUM-1:0] i_err_fatal,
  input  logic [ERR_NUM-1:0] i_err_clr,
  input  logic               i_fsenb_n,
  input  logic [3:0]         i_mode_req,
  output logic [7:0]         o_ctrl_vec,
  output logic               o_int_n,
  output logic [ERR_NUM-1:0] o_err_lock,
  output logic [3:0]         o_cur_st
);

  localparam logic [3:0] ST_POWER_DOWN = 4'd0;
  localparam logic [3:0] ST_WAIT       = 4'd1;
  localparam logic [3:0] ST_TEST       = 4'd2;
  localparam logic [3:0] ST_NORMAL     = 4'd3;
  localparam logic [3:0] ST_FAILSAFE   = 4'd4;
  localparam logic [3:0] ST_FAULT      = 4'd5;
  localparam logic [3:0] ST_CFG        = 4'd6;
  localparam logic [3:0] ST_RST        = 4'd7;
  localparam logic [3:0] ST_BIST       = 4'd8;

  localparam logic [7:0] ADC_TARGET = 8'(REQ_ADC_NUM);
  localparam logic [7:0] RST_LAST   = 8'(RST_HOLD_CYC - 1);

  // Mode request fields: {sft_rst, bist_en, cfg_en, normal_en}.
  logic sft_rst;
  logic bist_en;
  logic cfg_en;
  logic normal_en;

  assign sft_rst   = i_mode_req[3];
  assign cfg_en    = i_mode_req[1];
  assign normal_en = i_mode_req[0];

`ifdef LV_MODE_FSM_BIST_EN
  localparam logic [7:0] CTRL_KEEP = 8'hFF;
  assign bist_en = i_mode_req[2];
`else
  // BIST compiled out: request bit is deliberately ignored, bist output bit forced low.
  localparam logic [7:0] CTRL_KEEP = 8'hEF;
  logic unused_bist_req;
  assign bist_en         = 1'b0;
  assign unused_bist_req = i_mode_req[2];
`endif

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       done_lock;
  logic       efuse_rdy;
  logic [7:0] adc_cnt;
  logic       adc_done;
  logic       adc_active;
  logic       adc_ack_ok;
  logic [7:0] rst_cnt;
  logic       fatal_hit;
  logic       any_err;
  logic       lock_en;
  logic [ERR_NUM-1:0] lock_set;
  logic [ERR_NUM-1:0] lock_clr;

  assign o_cur_st  = state;
  assign efuse_rdy = i_efuse_vld | done_lock;
  assign adc_done  = (adc_cnt == ADC_TARGET);
  assign fatal_hit = |(o_err_lock & i_err_fatal);
  assign any_err   = (|o_err_lock) | ~i_fsenb_n;

  // Control-vector encoding per state: {fsafe, ow_comm, cfg, bist, spi, ow_wdg, crc_wdg, pwm}.
  function automatic logic [7:0] ctrl_of(input logic [3:0] st);
    case (st)
      ST_WAIT, ST_TEST: ctrl_of = 8'h48;
      ST_NORMAL:        ctrl_of = 8'h4F;
      ST_FAILSAFE:      ctrl_of = 8'hC8;
      ST_FAULT:         ctrl_of = 8'h08;
      ST_CFG:           ctrl_of = 8'h68;
      ST_BIST:          ctrl_of = 8'h58;
      default:          ctrl_of = 8'h00;
    endcase
  endfunction

  // Next-state decision; power loss overrides every other transition.
  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_POWER_DOWN: begin
        if (i_power_on) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (efuse_rdy) begin
          if (i_test_mode)                state_nxt = ST_TEST;
          else if (adc_done && normal_en) state_nxt = ST_NORMAL;
        end
      end
      ST_TEST: begin
        if (!i_test_mode) state_nxt = ST_WAIT;
      end
      ST_NORMAL, ST_CFG, ST_BIST: begin
        if (fatal_hit)    state_nxt = ST_FAULT;
        else if (any_err) state_nxt = ST_FAILSAFE;
        else if (sft_rst) state_nxt = ST_RST;
        else if (state == ST_NORMAL) begin
          if (cfg_en)       state_nxt = ST_CFG;
          else if (bist_en) state_nxt = ST_BIST;
        end else if (state == ST_CFG) begin
          if (!cfg_en) state_nxt = ST_NORMAL;
        end else begin
          // BIST; in a build without BIST this also recovers a stray encoding.
          if (!bist_en) state_nxt = ST_NORMAL;
        end
      end
      ST_FAILSAFE: begin
        if (fatal_hit)                      state_nxt = ST_FAULT;
        else if (sft_rst)                   state_nxt = ST_RST;
        else if (!(|o_err_lock) && i_fsenb_n) state_nxt = ST_NORMAL;
      end
      ST_FAULT: begin
        if (sft_rst) state_nxt = ST_RST;
      end
      ST_RST: begin
        if (rst_cnt == RST_LAST) state_nxt = ST_WAIT;
      end
      default: state_nxt = ST_POWER_DOWN;
    endcase
    if (!i_power_on) state_nxt = ST_POWER_DOWN;
  end

  // State register and outputs registered from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_POWER_DOWN;
      o_ctrl_vec <= 8'h00;
      o_int_n    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nxt;
      o_ctrl_vec <= ctrl_of(state_nxt) & CTRL_KEEP;
      o_int_n    <= ~((state_nxt == ST_FAILSAFE) | (state_nxt == ST_FAULT) | (|o_err_lock));
    end
  end

  // RST dwell counter: runs only while staying in RST, so sft_rst cannot restart it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_cnt <= 8'd0;
    end else if ((state == ST_RST) && (state_nxt == ST_RST)) begin
      rst_cnt <= rst_cnt + 8'd1;
    end else begin
      rst_cnt <= 8'd0;
    end
  end

  // Sticky error flags: set wins over write-1-to-clear; no capture in POWER_DOWN/RST.
  assign lock_en  = (state != ST_POWER_DOWN) && (state != ST_RST);
  assign lock_set = lock_en ? i_err_vec : '0;
  assign lock_clr = i_err_clr & ~i_err_vec;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_lock <= '0;
    end else begin
      o_err_lock <= (o_err_lock & ~lock_clr) | lock_set;
    end
  end

  // Efuse load pulse on the POWER_DOWN->WAIT step when efuse data is not yet valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fsm_efuse_load_en <= 1'b0;
    end else begin
      o_fsm_efuse_load_en <= (state == ST_POWER_DOWN) && i_power_on && !i_efuse_vld;
    end
  end

  // Remember load completion; a new load request discards any earlier completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      done_lock <= 1'b0;
    end else if (o_fsm_efuse_load_en) begin
      done_lock <= 1'b0;
    end else if (i_efuse_fsm_load_done) begin
      done_lock <= 1'b1;
    end
  end

  // ADC handshake: request only while staying in WAIT with efuse ready and acks
  // still owed. After an ack the request drops for one idle cycle, then re-arms.
  assign adc_active = (state == ST_WAIT) && (state_nxt == ST_WAIT) && efuse_rdy && !adc_done;
  assign adc_ack_ok = o_fsm_ow_ctrl_req_adc && i_ow_ctrl_fsm_ack_adc &&
                      !i_ow_ctrl_fsm_ack_adc_status && (state == ST_WAIT) && !adc_done;

  // Request register; leaving WAIT (including power loss) drops it immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fsm_ow_ctrl_req_adc <= 1'b0;
    end else begin
      o_fsm_ow_ctrl_req_adc <= adc_active && !(o_fsm_ow_ctrl_req_adc && i_ow_ctrl_fsm_ack_adc);
    end
  end

  // Successful-ack counter, saturating at the target; cleared in POWER_DOWN and RST.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      adc_cnt <= 8'd0;
    end else if ((state == ST_POWER_DOWN) || (state == ST_RST)) begin
      adc_cnt <= 8'd0;
    end else if (adc_ack_ok) begin
      adc_cnt <= adc_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_lv_mode_fsm.sv
// tb_lv_mode_fsm: scoreboard bench for lv_mode_fsm. A mode-level reference model
// predicts each cycle's outputs and queues them; a monitor compares DUT outputs.
module tb_lv_mode_fsm;

  localparam int ERR_NUM      = 13;
  localparam int REQ_ADC_NUM  = 4;
  localparam int RST_HOLD_CYC = 8;

  typedef enum logic [3:0] {
    M_PD = 4'd0, M_WAIT = 4'd1, M_TEST = 4'd2, M_NORMAL = 4'd3, M_FS = 4'd4,
    M_FAULT = 4'd5, M_CFG = 4'd6, M_RST = 4'd7, M_BIST = 4'd8
  } mode_e;

  localparam logic [7:0] CTRL_TAB [0:8] = '{8'h00, 8'h48, 8'h48, 8'h4F, 8'hC8,
                                            8'h08, 8'h68, 8'h00, 8'h58};

  typedef struct {
    logic [3:0]         st;
    logic [7:0]         ctrl;
    logic               int_n;
    logic [ERR_NUM-1:0] lock;
    logic               req;
    logic               load;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic power_on = 1'b0, test_mode = 1'b0, efuse_vld = 1'b0, load_done = 1'b0;
  logic ack_adc = 1'b0, ack_status = 1'b0, fsenb_n = 1'b1;
  logic [ERR_NUM-1:0] err_vec = '0, err_fatal = '0, err_clr = '0;
  logic [3:0] mode_req = 4'b0000;
  logic load_en, req_adc, int_n;
  logic [7:0] ctrl_vec;
  logic [ERR_NUM-1:0] err_lock;
  logic [3:0] cur_st;

  lv_mode_fsm #(.ERR_NUM(ERR_NUM), .REQ_ADC_NUM(REQ_ADC_NUM), .RST_HOLD_CYC(RST_HOLD_CYC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_power_on(power_on), .i_test_mode(test_mode),
    .i_efuse_vld(efuse_vld), .o_fsm_efuse_load_en(load_en), .i_efuse_fsm_load_done(load_done),
    .o_fsm_ow_ctrl_req_adc(req_adc), .i_ow_ctrl_fsm_ack_adc(ack_adc),
    .i_ow_ctrl_fsm_ack_adc_status(ack_status), .i_err_vec(err_vec), .i_err_fatal(err_fatal),
    .i_err_clr(err_clr), .i_fsenb_n(fsenb_n), .i_mode_req(mode_req), .o_ctrl_vec(ctrl_vec),
    .o_int_n(int_n), .o_err_lock(err_lock), .o_cur_st(cur_st)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  bit status_q[$];

  // Reference model state (values visible on DUT outputs after the last edge).
  mode_e m_mode = M_PD;
  logic [ERR_NUM-1:0] m_lock = '0;
  bit m_done_lock = 0, m_req = 0, m_load = 0;
  int m_cnt = 0, m_rst_age = 0;

  // Responder knobs and observation counters.
  bit auto_ack = 1, spurious = 0, rand_status = 0;
  int ack_slow = 0, acks_given = 0;
  int load_seen = 0, req_rises = 0, rst_seen = 0;
  logic req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the behavioural model: next mode from the mode rules, then outputs.
  task automatic model_step();
    mode_e nxt;
    logic [ERR_NUM-1:0] lock_n;
    bit rdy, fatal_hit, any_err, ack_ok, active, sft, cfg, nrm, bist;
    exp_t e;
    sft = mode_req[3]; bist = mode_req[2]; cfg = mode_req[1]; nrm = mode_req[0];
`ifndef LV_MODE_FSM_BIST_EN
    bist = 0;
`endif
    rdy       = efuse_vld || m_done_lock;
    fatal_hit = (m_lock & err_fatal) != '0;
    any_err   = (m_lock != '0) || !fsenb_n;
    nxt = m_mode;
    if (!power_on) nxt = M_PD;
    else begin
      case (m_mode)
        M_PD:    nxt = M_WAIT;
        M_WAIT:  if (rdy && test_mode) nxt = M_TEST;
                 else if (rdy && m_cnt == REQ_ADC_NUM && nrm) nxt = M_NORMAL;
        M_TEST:  if (!test_mode) nxt = M_WAIT;
        M_FS:    if (fatal_hit) nxt = M_FAULT;
                 else if (sft) nxt = M_RST;
                 else if (m_lock == '0 && fsenb_n) nxt = M_NORMAL;
        M_FAULT: if (sft) nxt = M_RST;
        M_RST:   if (m_rst_age + 1 == RST_HOLD_CYC) nxt = M_WAIT;
        default: begin
          if (fatal_hit) nxt = M_FAULT;
          else if (any_err) nxt = M_FS;
          else if (sft) nxt = M_RST;
          else if (m_mode == M_NORMAL && cfg) nxt = M_CFG;
          else if (m_mode == M_NORMAL && bist) nxt = M_BIST;
          else if (m_mode == M_CFG && !cfg) nxt = M_NORMAL;
          else if (m_mode == M_BIST && !bist) nxt = M_NORMAL;
        end
      endcase
    end
    for (int i = 0; i < ERR_NUM; i++) begin
      if (err_vec[i] && m_mode != M_PD && m_mode != M_RST) lock_n[i] = 1'b1;
      else if (err_clr[i] && !err_vec[i]) lock_n[i] = 1'b0;
      else lock_n[i] = m_lock[i];
    end
    ack_ok = ack_adc && m_req && !ack_status && m_cnt < REQ_ADC_NUM;
    active = m_mode == M_WAIT && nxt == M_WAIT && rdy && m_cnt < REQ_ADC_NUM;
    e.st    = nxt;
    e.ctrl  = CTRL_TAB[int'(nxt)];
    e.int_n = !(nxt == M_FS || nxt == M_FAULT) && m_lock == '0;
    e.lock  = lock_n;
    e.req   = active && !(m_req && ack_adc);
    e.load  = m_mode == M_PD && power_on && !efuse_vld;
    exp_q.push_back(e);
    m_done_lock = m_load ? 1'b0 : (load_done ? 1'b1 : m_done_lock);
    m_cnt       = (m_mode == M_PD || m_mode == M_RST) ? 0 : m_cnt + int'(ack_ok);
    m_rst_age   = (m_mode == M_RST && nxt == M_RST) ? m_rst_age + 1 : 0;
    m_mode = nxt; m_lock = lock_n; m_req = e.req; m_load = e.load;
  endtask

  // Drive the ADC responder, run the model for this cycle and advance one clock.
  task automatic tick();
    if (auto_ack) begin
      if (m_req && $urandom_range(0, ack_slow) == 0) begin
        ack_adc = 1'b1;
        if (status_q.size() > 0) ack_status = status_q.pop_front();
        else if (rand_status)    ack_status = ($urandom_range(0, 2) == 0);
        else                     ack_status = 1'b0;
        acks_given++;
      end else begin
        ack_adc    = spurious && ($urandom_range(0, 9) == 0);
        ack_status = 1'($urandom_range(0, 1));
      end
    end
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(cur_st), 32'd0);
    check("rst_ctrl", 32'(ctrl_vec), 32'h00);
    check("rst_int_n", 32'(int_n), 32'd1);
    check("rst_lock", 32'(err_lock), 32'd0);
    check("rst_req", 32'(req_adc), 32'd0);
    check("rst_load", 32'(load_en), 32'd0);
    m_mode = M_PD; m_lock = '0; m_done_lock = 0; m_req = 0; m_load = 0;
    m_cnt = 0; m_rst_age = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until(input mode_e target, input int max_cyc, input string name);
    int n = 0;
    while (m_mode != target && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, 32'(cur_st), 32'(target));
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!m_req && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(req_adc), 32'd1);
  endtask

  // Monitor: compares every presented output cycle against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (cur_st == 4'd7) rst_seen++;
      if (load_en) load_seen++;
      if (req_adc && !req_prev) req_rises++;
      req_prev = req_adc;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_state", 32'(cur_st), 32'(e.st));
        check("sb_ctrl", 32'(ctrl_vec), 32'(e.ctrl));
        check("sb_int_n", 32'(int_n), 32'(e.int_n));
        check("sb_lock", 32'(err_lock), 32'(e.lock));
        check("sb_req", 32'(req_adc), 32'(e.req));
        check("sb_load", 32'(load_en), 32'(e.load));
      end
    end
  end

  initial begin
    int base_load, base_req, base_rst, base_ack;
    #2;
    do_reset();

    // Power-up with efuse load, done 3 cycles later, four clean acks.
    power_on = 1'b1; efuse_vld = 1'b0; mode_req = 4'b0001;
    base_load = load_seen; base_req = req_rises;
    tick(); tick(); tick();
    load_done = 1'b1; tick(); load_done = 1'b0;
    run_until(M_NORMAL, 60, "powerup_normal");
    check("powerup_load_pulses", 32'(load_seen - base_load), 32'd1);
    check("powerup_requests", 32'(req_rises - base_req), 32'd4);
    check("powerup_ctrl", 32'(ctrl_vec), 32'h4F);

    // Soft reset, then acks with mixed status: NORMAL only after the 4th good ack.
    base_rst = rst_seen;
    mode_req = 4'b1001; tick(); tick(); tick(); mode_req = 4'b0001;
    run_until(M_WAIT, 20, "sftrst_wait");
    check("rst_hold_cycles", 32'(rst_seen - base_rst), 32'(RST_HOLD_CYC));
    status_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    base_ack = acks_given;
    run_until(M_NORMAL, 80, "mixed_ack_normal");
    check("mixed_ack_count", 32'(acks_given - base_ack), 32'd6);

    // Non-fatal error then W1C after it drops: FAILSAFE and back.
    err_fatal = '0; err_vec = ERR_NUM'(1) << 2; tick();
    err_vec = '0; tick();
    check("fs_state", 32'(cur_st), 32'd4);
    check("fs_ctrl", 32'(ctrl_vec), 32'hC8);
    check("fs_int_n", 32'(int_n), 32'd0);
    err_clr = ERR_NUM'(1) << 2; tick(); err_clr = '0; tick();
    check("fs_exit_state", 32'(cur_st), 32'd3);
    check("fs_exit_int_n", 32'(int_n), 32'd1);

    // In FAILSAFE, fatal bit 5 with same-cycle clear: lock holds, FAULT, then soft reset.
    fsenb_n = 1'b0; tick();
    err_vec = ERR_NUM'(1) << 5; err_fatal = ERR_NUM'(1) << 5; err_clr = ERR_NUM'(1) << 5; tick();
    err_vec = '0; err_clr = '0; fsenb_n = 1'b1; tick();
    check("fault_state", 32'(cur_st), 32'd5);
    check("fault_ctrl", 32'(ctrl_vec), 32'h08);
    check("fault_lock5", 32'(err_lock[5]), 32'd1);
    base_rst = rst_seen;
    mode_req = 4'b1001; tick(); tick(); mode_req = 4'b0001;
    run_until(M_WAIT, 20, "fault_rst_wait");
    check("fault_rst_cycles", 32'(rst_seen - base_rst), 32'(RST_HOLD_CYC));
    err_fatal = '0; err_clr = ERR_NUM'(1) << 5; tick(); err_clr = '0;
    run_until(M_NORMAL, 60, "refill_normal");

    // Power loss in CFG and mid-request in WAIT.
    mode_req = 4'b0011; tick();
    check("cfg_state", 32'(cur_st), 32'd6);
    check("cfg_ctrl", 32'(ctrl_vec), 32'h68);
    power_on = 1'b0; tick();
    check("pwroff_cfg_state", 32'(cur_st), 32'd0);
    check("pwroff_cfg_ctrl", 32'(ctrl_vec), 32'h00);
    check("pwroff_cfg_req", 32'(req_adc), 32'd0);
    mode_req = 4'b0001; power_on = 1'b1; efuse_vld = 1'b1;
    run_until(M_WAIT, 5, "repower_wait");
    auto_ack = 0; ack_adc = 1'b0;
    wait_req("req_before_pwroff");
    power_on = 1'b0; tick();
    check("pwroff_wait_req", 32'(req_adc), 32'd0);
    check("pwroff_wait_state", 32'(cur_st), 32'd0);
    auto_ack = 1; power_on = 1'b1;
    run_until(M_NORMAL, 60, "repower_normal");

    // BIST request in NORMAL.
    mode_req = 4'b0101; tick(); tick();
`ifdef LV_MODE_FSM_BIST_EN
    check("bist_state", 32'(cur_st), 32'd8);
    check("bist_ctrl", 32'(ctrl_vec), 32'h58);
    mode_req = 4'b0001; tick();
    check("bist_exit", 32'(cur_st), 32'd3);
`else
    check("nobist_state", 32'(cur_st), 32'd3);
    check("nobist_ctrl4", 32'(ctrl_vec[4]), 32'd0);
    mode_req = 4'b0001; tick();
`endif

    // Reset asserted while a request is outstanding.
    power_on = 1'b0; tick(); power_on = 1'b1;
    run_until(M_WAIT, 5, "pre_abort_wait");
    auto_ack = 0; ack_adc = 1'b0;
    wait_req("req_before_reset");
    do_reset();
    auto_ack = 1;
    base_load = load_seen;
    repeat (6) tick();
    check("post_reset_no_load", 32'(load_seen - base_load), 32'd0);

    // Randomised run checked only by the scoreboard.
    spurious = 1; rand_status = 1; ack_slow = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      power_on  = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 79) == 0)  test_mode = ~test_mode;
      if ($urandom_range(0, 149) == 0) efuse_vld = ~efuse_vld;
      load_done = ($urandom_range(0, 24) == 0);
      err_vec   = ($urandom_range(0, 59) == 0) ? ERR_NUM'(1) << $urandom_range(0, ERR_NUM - 1) : '0;
      if ($urandom_range(0, 199) == 0) err_fatal = ERR_NUM'($urandom);
      err_clr   = ($urandom_range(0, 9) == 0) ? ERR_NUM'($urandom) : '0;
      fsenb_n   = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 14) == 0) mode_req[1] = ~mode_req[1];
      if ($urandom_range(0, 14) == 0) mode_req[2] = ~mode_req[2];
      if ($urandom_range(0, 19) == 0) mode_req[0] = ~mode_req[0];
      mode_req[3] = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
